fetch_stage: RTL

Instruction-fetch stage of the pipelined RV32I core: owns the program counter, applies the 2-bit PCSrc redirect code from the execute-stage PC-select logic, and drives a variable-latency instruction-memory request/valid interface. Holds the IF/ID pipeline register, including the stall, flush and bubble handling, and discards wrong-path fetches. Sits between PC-select/hazard control and the decode stage.

---
 rtl/fetch_stage.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with PC, redirect, variable-latency IMem handshake and IF/ID register.
// Optional macro MISALIGN_TRAP_EN: redirect targets with bit 1 set go to TRAP_VEC and pulse TrapF.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0010,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  input  logic        Stall,
  input  logic        FlushD,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemValid,
  input  logic [31:0] IMemRdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        TrapF
);
  typedef enum logic [1:0] {BOOT, REQ, HOLD, DRAIN} state_t;
  state_t r_state, w_next;
  logic [31:0] r_pcf, r_buf, r_redir_pc;
  logic [31:0] w_pcf_nxt, w_buf_nxt, w_redir_nxt, w_raw, w_tgt, w_word, w_pcf_p4;
  logic w_redir, w_got, w_load;

  assign w_redir  = PCSrc == 2'b01 || PCSrc == 2'b10;
  assign w_raw    = PCSrc == 2'b01 ? PCTargetE : (ALUResultE & 32'hFFFF_FFFE);
  assign w_pcf_p4 = r_pcf + 32'd4;
`ifdef MISALIGN_TRAP_EN
  assign w_tgt    = w_raw[1] ? TRAP_VEC : w_raw;
`else
  assign w_tgt    = w_raw & 32'hFFFF_FFFC;
`endif
  assign IMemReq  = r_state == REQ || r_state == DRAIN;
  assign IMemAddr = r_pcf;
  assign w_load   = w_got && !FlushD;

  // A word is only ever delivered to IF/ID when no redirect is being taken.
  always_comb begin
    w_next      = r_state;
    w_pcf_nxt   = r_pcf;
    w_buf_nxt   = r_buf;
    w_redir_nxt = r_redir_pc;
    w_got       = 1'b0;
    w_word      = r_buf;
    case (r_state)
      BOOT: w_next = REQ;
      REQ:
        if (w_redir) begin
          if (IMemValid) w_pcf_nxt = w_tgt;
          else begin
            w_redir_nxt = w_tgt;
            w_next      = DRAIN;
          end
        end else if (IMemValid) begin
          if (Stall) begin
            w_buf_nxt = IMemRdata;
            w_next    = HOLD;
          end else begin
            w_got     = 1'b1;
            w_word    = IMemRdata;
            w_pcf_nxt = w_pcf_p4;
          end
        end
      HOLD:
        if (w_redir) begin
          w_pcf_nxt = w_tgt;
          w_next    = REQ;
        end else if (!Stall) begin
          w_got     = 1'b1;
          w_pcf_nxt = w_pcf_p4;
          w_next    = REQ;
        end
      DRAIN: begin
        if (w_redir) w_redir_nxt = w_tgt;
        if (IMemValid) begin
          w_pcf_nxt = w_redir ? w_tgt : r_redir_pc;
          w_next    = REQ;
        end
      end
      default: w_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= BOOT;
      r_pcf      <= RESET_PC;
      r_buf      <= '0;
      r_redir_pc <= '0;
      InstrD     <= NOP_INSTR;
      PCD        <= '0;
      PCPlus4D   <= '0;
      ValidD     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_pcf      <= w_pcf_nxt;
      r_buf      <= w_buf_nxt;
      r_redir_pc <= w_redir_nxt;
      if (FlushD || !Stall) begin
        InstrD <= w_load ? w_word : NOP_INSTR;
        ValidD <= w_load;
        if (w_load) begin
          PCD      <= r_pcf;
          PCPlus4D <= w_pcf_p4;
        end
      end
    end

`ifdef MISALIGN_TRAP_EN
  logic r_trap;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_trap <= 1'b0;
    else r_trap <= w_redir && r_state != BOOT && w_raw[1];
  assign TrapF = r_trap;
`else
  assign TrapF = 1'b0;
`endif
endmodule
